// File: rtl/mem_port_arbiter_pkg.sv
// Shared types and constants for the ram port arbiter.
// Optional feature macro: MEM_ARB_DEBUG_PORT_EN (adds a top-priority debug requester).
package mem_port_arbiter_pkg;

  localparam int STARVE_CNT_BITS = 4;

  typedef enum logic [2:0] {
    IDLE,
    RD_ISSUE,
    RD_CAPTURE,
    WR_DRIVE,
    WR_COMMIT
  } mem_arb_state_t;

  typedef enum logic [1:0] {
    OWN_IF,
    OWN_LS,
    OWN_DBG
  } mem_arb_owner_t;

endpackage

// File: rtl/mem_port_arbiter_if.sv
// Requester handshakes plus ram control pins. The ram data net stays a plain inout on the top.
// Optional feature macro: MEM_ARB_DEBUG_PORT_EN (adds the dbg_* requester signals).
interface mem_port_arbiter_if #(
  parameter int ADDR_BITS = 8,
  parameter int DATA_BITS = 8
);
  logic                 if_req;
  logic [ADDR_BITS-1:0] if_addr;
  logic                 if_gnt;
  logic                 if_done;
  logic [DATA_BITS-1:0] if_rdata;

  logic                 ls_req;
  logic                 ls_we;
  logic [ADDR_BITS-1:0] ls_addr;
  logic [DATA_BITS-1:0] ls_wdata;
  logic                 ls_gnt;
  logic                 ls_done;
  logic [DATA_BITS-1:0] ls_rdata;

  logic [ADDR_BITS-1:0] mem_address;
  logic                 mem_out_en;
  logic                 mem_write_en;

`ifdef MEM_ARB_DEBUG_PORT_EN
  logic                 dbg_req;
  logic                 dbg_we;
  logic [ADDR_BITS-1:0] dbg_addr;
  logic [DATA_BITS-1:0] dbg_wdata;
  logic                 dbg_gnt;
  logic                 dbg_done;
  logic [DATA_BITS-1:0] dbg_rdata;

  modport master (
    output if_req, if_addr, ls_req, ls_we, ls_addr, ls_wdata,
           dbg_req, dbg_we, dbg_addr, dbg_wdata,
    input  if_gnt, if_done, if_rdata, ls_gnt, ls_done, ls_rdata,
           dbg_gnt, dbg_done, dbg_rdata, mem_address, mem_out_en, mem_write_en
  );
  modport slave (
    input  if_req, if_addr, ls_req, ls_we, ls_addr, ls_wdata,
           dbg_req, dbg_we, dbg_addr, dbg_wdata,
    output if_gnt, if_done, if_rdata, ls_gnt, ls_done, ls_rdata,
           dbg_gnt, dbg_done, dbg_rdata, mem_address, mem_out_en, mem_write_en
  );
`else
  modport master (
    output if_req, if_addr, ls_req, ls_we, ls_addr, ls_wdata,
    input  if_gnt, if_done, if_rdata, ls_gnt, ls_done, ls_rdata,
           mem_address, mem_out_en, mem_write_en
  );
  modport slave (
    input  if_req, if_addr, ls_req, ls_we, ls_addr, ls_wdata,
    output if_gnt, if_done, if_rdata, ls_gnt, ls_done, ls_rdata,
           mem_address, mem_out_en, mem_write_en
  );
`endif
endinterface

// File: rtl/mem_port_arbiter_select.sv
// Winner picker: load/store over fetch, with a starvation counter that forces fetch through.
// Optional feature macro: MEM_ARB_DEBUG_PORT_EN (debug beats everything, counter frozen on its grants).
module mem_arb_select
  import mem_port_arbiter_pkg::*;
#(
  parameter int STARVE_LIMIT = 3
) (
  input  logic           clk,
  input  logic           reset_n,
  input  logic           if_req,
  input  logic           ls_req,
`ifdef MEM_ARB_DEBUG_PORT_EN
  input  logic           dbg_req,
`endif
  input  logic           idle_stb,
  output mem_arb_owner_t owner,
  output logic           valid
);

  localparam logic [STARVE_CNT_BITS-1:0] LIMIT = STARVE_CNT_BITS'(STARVE_LIMIT);

  logic [STARVE_CNT_BITS-1:0] starve_q, starve_d;

  // Priority pick; later assignments override earlier ones, so the last one listed wins.
  always_comb begin
    owner = OWN_LS;
    valid = 1'b0;
    if (ls_req) begin
      owner = OWN_LS;
      valid = 1'b1;
    end
    if (if_req && (!ls_req || starve_q == LIMIT)) begin
      owner = OWN_IF;
      valid = 1'b1;
    end
`ifdef MEM_ARB_DEBUG_PORT_EN
    if (dbg_req) begin
      owner = OWN_DBG;
      valid = 1'b1;
    end
`endif
  end

  // Starvation count: bumps on LS grants while fetch waits, clears when fetch is idle or served.
  always_comb begin
    starve_d = starve_q;
    if (idle_stb && valid && owner == OWN_DBG) begin
      starve_d = starve_q;
    end else if (!if_req) begin
      starve_d = '0;
    end else if (idle_stb && valid) begin
      if (owner == OWN_IF) begin
        starve_d = '0;
      end else if (starve_q != {STARVE_CNT_BITS{1'b1}}) begin
        starve_d = starve_q + 1'b1;
      end
    end
  end

  // Starvation counter register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) starve_q <= '0;
    else          starve_q <= starve_d;
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Single-port ram arbiter between fetch and load/store; owns the ram data tristate.
// Optional feature macro: MEM_ARB_DEBUG_PORT_EN (third, top-priority debug requester).
module mem_port_arbiter
  import mem_port_arbiter_pkg::*;
#(
  parameter int ADDR_BITS    = 8,
  parameter int DATA_BITS    = 8,
  parameter int STARVE_LIMIT = 3
) (
  input  logic                 clk,
  input  logic                 reset_n,
  mem_port_arbiter_if.slave    bus,
  inout  wire  [DATA_BITS-1:0] mem_data
);

  mem_arb_state_t       state_q, state_d;
  mem_arb_owner_t       owner_q, sel_owner;
  logic                 sel_valid, sel_we;
  logic [ADDR_BITS-1:0] addr_q, sel_addr;
  logic [DATA_BITS-1:0] wdata_q, sel_wdata;
  logic                 if_gnt_q, if_done_q, ls_gnt_q, ls_done_q;
  logic [DATA_BITS-1:0] if_rdata_q, ls_rdata_q;
  logic                 out_en, write_en, drive_en;
  logic                 grant;
`ifdef MEM_ARB_DEBUG_PORT_EN
  logic                 dbg_gnt_q, dbg_done_q;
  logic [DATA_BITS-1:0] dbg_rdata_q;
`endif

  mem_arb_select #(.STARVE_LIMIT(STARVE_LIMIT)) u_select (
    .clk      (clk),
    .reset_n  (reset_n),
    .if_req   (bus.if_req),
    .ls_req   (bus.ls_req),
`ifdef MEM_ARB_DEBUG_PORT_EN
    .dbg_req  (bus.dbg_req),
`endif
    .idle_stb (state_q == IDLE),
    .owner    (sel_owner),
    .valid    (sel_valid)
  );

  assign grant = (state_q == IDLE) && sel_valid;

  // Mux the winning requester's address/direction/data toward the latch registers.
  always_comb begin
    sel_addr  = bus.ls_addr;
    sel_we    = bus.ls_we;
    sel_wdata = bus.ls_wdata;
    case (sel_owner)
      OWN_IF: begin
        sel_addr  = bus.if_addr;
        sel_we    = 1'b0;
        sel_wdata = '0;
      end
`ifdef MEM_ARB_DEBUG_PORT_EN
      OWN_DBG: begin
        sel_addr  = bus.dbg_addr;
        sel_we    = bus.dbg_we;
        sel_wdata = bus.dbg_wdata;
      end
`endif
      default: ;
    endcase
  end

  // FSM state register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state_q <= IDLE;
    else          state_q <= state_d;
  end

  // FSM next state: every access is exactly three states long including IDLE.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:       if (sel_valid) state_d = sel_we ? WR_DRIVE : RD_ISSUE;
      RD_ISSUE:   state_d = RD_CAPTURE;
      RD_CAPTURE: state_d = IDLE;
      WR_DRIVE:   state_d = WR_COMMIT;
      WR_COMMIT:  state_d = IDLE;
      default:    state_d = IDLE;
    endcase
  end

  // FSM outputs: read enable and write enable/data drive are disjoint by state.
  always_comb begin
    out_en   = (state_q == RD_ISSUE) || (state_q == RD_CAPTURE);
    write_en = (state_q == WR_COMMIT);
    drive_en = (state_q == WR_DRIVE) || (state_q == WR_COMMIT);
  end

  // Request latch, grant/done pulses and per-requester read data.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      addr_q      <= '0;
      wdata_q     <= '0;
      owner_q     <= OWN_IF;
      if_gnt_q    <= 1'b0;
      if_done_q   <= 1'b0;
      if_rdata_q  <= '0;
      ls_gnt_q    <= 1'b0;
      ls_done_q   <= 1'b0;
      ls_rdata_q  <= '0;
`ifdef MEM_ARB_DEBUG_PORT_EN
      dbg_gnt_q   <= 1'b0;
      dbg_done_q  <= 1'b0;
      dbg_rdata_q <= '0;
`endif
    end else begin
      if_gnt_q   <= grant && (sel_owner == OWN_IF);
      ls_gnt_q   <= grant && (sel_owner == OWN_LS);
      if_done_q  <= (state_q == RD_CAPTURE) && (owner_q == OWN_IF);
      ls_done_q  <= ((state_q == RD_CAPTURE) || (state_q == WR_COMMIT)) && (owner_q == OWN_LS);
`ifdef MEM_ARB_DEBUG_PORT_EN
      dbg_gnt_q  <= grant && (sel_owner == OWN_DBG);
      dbg_done_q <= ((state_q == RD_CAPTURE) || (state_q == WR_COMMIT)) && (owner_q == OWN_DBG);
`endif
      if (grant) begin
        addr_q  <= sel_addr;
        wdata_q <= sel_wdata;
        owner_q <= sel_owner;
      end
      if (state_q == RD_CAPTURE) begin
        case (owner_q)
          OWN_IF:  if_rdata_q  <= mem_data;
          OWN_LS:  ls_rdata_q  <= mem_data;
`ifdef MEM_ARB_DEBUG_PORT_EN
          OWN_DBG: dbg_rdata_q <= mem_data;
`endif
          default: ;
        endcase
      end
    end
  end

  assign mem_data         = drive_en ? wdata_q : {DATA_BITS{1'bz}};
  assign bus.mem_address  = addr_q;
  assign bus.mem_out_en   = out_en;
  assign bus.mem_write_en = write_en;
  assign bus.if_gnt       = if_gnt_q;
  assign bus.if_done      = if_done_q;
  assign bus.if_rdata     = if_rdata_q;
  assign bus.ls_gnt       = ls_gnt_q;
  assign bus.ls_done      = ls_done_q;
  assign bus.ls_rdata     = ls_rdata_q;
`ifdef MEM_ARB_DEBUG_PORT_EN
  assign bus.dbg_gnt      = dbg_gnt_q;
  assign bus.dbg_done     = dbg_done_q;
  assign bus.dbg_rdata    = dbg_rdata_q;
`endif

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Scoreboard bench for mem_port_arbiter: grant order and read data queued at stimulus time.
// Optional feature macro: MEM_ARB_DEBUG_PORT_EN (enables the debug-priority scenario).
module tb_mem_port_arbiter;

  localparam int AB = 8;
  localparam int DB = 8;
  localparam logic [31:0] G_IF  = 32'd0;
  localparam logic [31:0] G_LS  = 32'd1;
  localparam logic [31:0] G_DBG = 32'd2;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  wire [DB-1:0] mem_data;
  mem_port_arbiter_if #(.ADDR_BITS(AB), .DATA_BITS(DB)) bus ();

  mem_port_arbiter #(.ADDR_BITS(AB), .DATA_BITS(DB), .STARVE_LIMIT(3)) dut (
    .clk      (clk),
    .reset_n  (reset_n),
    .bus      (bus),
    .mem_data (mem_data)
  );

  // Ram model: asynchronous read while out_en, write on the edge ending write_en.
  logic [DB-1:0] ram    [0:255];
  logic [DB-1:0] shadow [0:255];
  assign mem_data = bus.mem_out_en ? ram[bus.mem_address] : {DB{1'bz}};
  always @(posedge clk) if (bus.mem_write_en) ram[bus.mem_address] <= mem_data;

  int tests = 0;
  int fails = 0;
  int cyc = 0;
  int if_gnt_cyc = 0, ls_gnt_cyc = 0;
  int we_cycles = 0;
  logic [DB-1:0] last_ls_load = '0;
  logic [31:0] gnt_exp [$];
  logic [DB-1:0] if_exp [$];
  logic [DB-1:0] ls_exp [$];
`ifdef MEM_ARB_DEBUG_PORT_EN
  logic [DB-1:0] dbg_exp [$];
`endif

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    if (obs !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic pop_gnt(input logic [31:0] who);
    if (gnt_exp.size() == 0) check("gnt_unexpected", who, 32'hFF);
    else                     check("gnt_order", who, gnt_exp.pop_front());
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // Output monitor: grants, done data and bus exclusivity sampled mid-cycle.
  always @(negedge clk) begin
    if (reset_n) begin
      check("rd_wr_excl", 32'(bus.mem_out_en & bus.mem_write_en), 32'd0);
      if (bus.mem_write_en) we_cycles++;
      if (bus.if_gnt) begin
        pop_gnt(G_IF);
        if_gnt_cyc = cyc;
        $display("[TB] t=%0t if_gnt addr=0x%0h", $time, bus.if_addr);
      end
      if (bus.ls_gnt) begin
        pop_gnt(G_LS);
        ls_gnt_cyc = cyc;
        $display("[TB] t=%0t ls_gnt we=%0d addr=0x%0h", $time, bus.ls_we, bus.ls_addr);
      end
      if (bus.if_done) begin
        check("if_latency", 32'(cyc - if_gnt_cyc), 32'd2);
        if (if_exp.size() == 0) check("if_done_unexpected", 32'd1, 32'd0);
        else check("if_rdata", 32'(bus.if_rdata), 32'(if_exp.pop_front()));
        $display("[TB] t=%0t if_done rdata=0x%0h", $time, bus.if_rdata);
      end
      if (bus.ls_done) begin
        check("ls_latency", 32'(cyc - ls_gnt_cyc), 32'd2);
        if (ls_exp.size() == 0) check("ls_done_unexpected", 32'd1, 32'd0);
        else check("ls_rdata", 32'(bus.ls_rdata), 32'(ls_exp.pop_front()));
        $display("[TB] t=%0t ls_done rdata=0x%0h", $time, bus.ls_rdata);
      end
`ifdef MEM_ARB_DEBUG_PORT_EN
      if (bus.dbg_gnt) pop_gnt(G_DBG);
      if (bus.dbg_done) begin
        if (dbg_exp.size() == 0) check("dbg_done_unexpected", 32'd1, 32'd0);
        else check("dbg_rdata", 32'(bus.dbg_rdata), 32'(dbg_exp.pop_front()));
        $display("[TB] t=%0t dbg_done rdata=0x%0h", $time, bus.dbg_rdata);
      end
`endif
    end
  end

  task automatic do_fetch(input logic [AB-1:0] a);
    bit got;
    if_exp.push_back(shadow[a]);
    bus.if_addr = a;
    bus.if_req  = 1'b1;
    got = 1'b0;
    for (int i = 0; i < 40 && !got; i++) begin
      @(negedge clk);
      if (bus.if_done) got = 1'b1;
    end
    if (!got) check("if_timeout", 32'd0, 32'd1);
    bus.if_req = 1'b0;
  endtask

  task automatic do_ls(input logic we, input logic [AB-1:0] a, input logic [DB-1:0] wd);
    bit got;
    if (we) shadow[a] = wd;
    else    last_ls_load = shadow[a];
    ls_exp.push_back(last_ls_load);
    bus.ls_we    = we;
    bus.ls_addr  = a;
    bus.ls_wdata = wd;
    bus.ls_req   = 1'b1;
    got = 1'b0;
    for (int i = 0; i < 40 && !got; i++) begin
      @(negedge clk);
      if (bus.ls_done) got = 1'b1;
    end
    if (!got) check("ls_timeout", 32'd0, 32'd1);
    bus.ls_req = 1'b0;
  endtask

`ifdef MEM_ARB_DEBUG_PORT_EN
  task automatic do_dbg(input logic [AB-1:0] a);
    bit got;
    dbg_exp.push_back(shadow[a]);
    bus.dbg_we   = 1'b0;
    bus.dbg_addr = a;
    bus.dbg_req  = 1'b1;
    got = 1'b0;
    for (int i = 0; i < 40 && !got; i++) begin
      @(negedge clk);
      if (bus.dbg_done) got = 1'b1;
    end
    if (!got) check("dbg_timeout", 32'd0, 32'd1);
    bus.dbg_req = 1'b0;
  endtask
`endif

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    bit got;
    for (int i = 0; i < 256; i++) begin
      ram[i]    = 8'(i) ^ 8'h5A;
      shadow[i] = 8'(i) ^ 8'h5A;
    end
    ram[8'h10] = 8'hA5;
    shadow[8'h10] = 8'hA5;
    bus.if_req = 1'b0; bus.if_addr = '0;
    bus.ls_req = 1'b0; bus.ls_we = 1'b0; bus.ls_addr = '0; bus.ls_wdata = '0;
`ifdef MEM_ARB_DEBUG_PORT_EN
    bus.dbg_req = 1'b0; bus.dbg_we = 1'b0; bus.dbg_addr = '0; bus.dbg_wdata = '0;
`endif

    // Reset state
    repeat (2) @(negedge clk);
    check("rst_if_gnt",   32'(bus.if_gnt), 32'd0);
    check("rst_ls_done",  32'(bus.ls_done), 32'd0);
    check("rst_out_en",   32'(bus.mem_out_en), 32'd0);
    check("rst_write_en", 32'(bus.mem_write_en), 32'd0);
    check("rst_address",  32'(bus.mem_address), 32'd0);
    check("rst_if_rdata", 32'(bus.if_rdata), 32'd0);
    reset_n = 1'b1;
    @(negedge clk);

    // Fetch only
    gnt_exp.push_back(G_IF);
    do_fetch(8'h10);

    // Store then load; write_en must be high for exactly one cycle
    gnt_exp.push_back(G_LS);
    we_cycles = 0;
    do_ls(1'b1, 8'h20, 8'h3C);
    check("store_we_cycles", 32'(we_cycles), 32'd1);
    check("ram_0x20", 32'(ram[8'h20]), 32'h3C);
    gnt_exp.push_back(G_LS);
    do_ls(1'b0, 8'h20, 8'h00);
    check("if_rdata_hold", 32'(bus.if_rdata), 32'hA5);

    // Simultaneous requests: LS first, fetch on the next IDLE
    gnt_exp.push_back(G_LS);
    gnt_exp.push_back(G_IF);
    fork
      do_ls(1'b0, 8'h33, 8'h00);
      do_fetch(8'h44);
    join

    // Starvation guard with STARVE_LIMIT=3
    gnt_exp.push_back(G_LS); gnt_exp.push_back(G_LS); gnt_exp.push_back(G_LS);
    gnt_exp.push_back(G_IF);
    gnt_exp.push_back(G_LS); gnt_exp.push_back(G_LS); gnt_exp.push_back(G_LS);
    gnt_exp.push_back(G_IF);
    fork
      begin
        for (int k = 0; k < 6; k++) do_ls(1'b0, 8'h50 + 8'(k), 8'h00);
      end
      begin
        for (int k = 0; k < 2; k++) do_fetch(8'h60 + 8'(k));
      end
    join

    // Reset during WR_COMMIT aborts the store with no done
    gnt_exp.push_back(G_LS);
    bus.ls_we = 1'b1; bus.ls_addr = 8'h70; bus.ls_wdata = 8'hC3; bus.ls_req = 1'b1;
    got = 1'b0;
    for (int i = 0; i < 20 && !got; i++) begin
      @(negedge clk);
      if (bus.mem_write_en) got = 1'b1;
    end
    check("wr_commit_seen", 32'(got), 32'd1);
    #1 reset_n = 1'b0;
    #1;
    check("abort_write_en", 32'(bus.mem_write_en), 32'd0);
    check("abort_out_en",   32'(bus.mem_out_en), 32'd0);
    check("abort_address",  32'(bus.mem_address), 32'd0);
    check("abort_ls_done",  32'(bus.ls_done), 32'd0);
    check("abort_ls_rdata", 32'(bus.ls_rdata), 32'd0);
    bus.ls_req = 1'b0;
    last_ls_load = '0;
    @(negedge clk);
    reset_n = 1'b1;
    repeat (4) @(negedge clk);
    check("ram_0x70_untouched", 32'(ram[8'h70]), 32'(shadow[8'h70]));
    gnt_exp.push_back(G_IF);
    do_fetch(8'h11);

`ifdef MEM_ARB_DEBUG_PORT_EN
    // Debug beats load/store and fetch
    gnt_exp.push_back(G_DBG);
    gnt_exp.push_back(G_LS);
    gnt_exp.push_back(G_IF);
    fork
      do_dbg(8'h80);
      do_ls(1'b0, 8'h81, 8'h00);
      do_fetch(8'h82);
    join
`endif

    repeat (4) @(negedge clk);
    check("gnt_queue_drained", 32'(gnt_exp.size()), 32'd0);
    check("if_queue_drained",  32'(if_exp.size()), 32'd0);
    check("ls_queue_drained",  32'(ls_exp.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
